minibyte_cpu_p: RTL and testbench

Parametrised next-generation MiniByte accumulator CPU core: data width and address width are parameters, and every memory access uses a request/ready handshake with unbounded wait states. It replaces the fixed 8-bit core at the top of the tile, driving the external memory/IO bus directly. It contains:
- the A, M, PC, IR and CCR registers;
- an ALU;
- a multi-cycle control FSM;
- a DFT debug mux on the address output.

---
 rtl/minibyte_pkg.sv | 53 +++++
 rtl/minibyte_alu_p.sv | 32 +++
 rtl/minibyte_cpu_p.sv | 182 ++++++++++++++++++
 tb/tb_minibyte_cpu_p.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minibyte_pkg.sv
// Shared constants for the parametrised MiniByte accumulator core:
// opcodes, FSM state encoding, debug-mux selects and opcode class helpers.
package minibyte_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_ANDI = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_ORI  = 4'hA;
  localparam logic [3:0] OP_XORI = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_BN   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPER   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] TM_BUS   = 3'd0;
  localparam logic [2:0] TM_ACC   = 3'd1;
  localparam logic [2:0] TM_ASIGN = 3'd2;
  localparam logic [2:0] TM_MREG  = 3'd3;
  localparam logic [2:0] TM_PC    = 3'd4;
  localparam logic [2:0] TM_IR    = 3'd5;
  localparam logic [2:0] TM_CCR   = 3'd6;
  localparam logic [2:0] TM_STATE = 3'd7;

  // CCR is packed as {Z, N}
  localparam int CCR_Z = 1;
  localparam int CCR_N = 0;

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI) ||
           (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/minibyte_alu_p.sv
// Combinational ALU: maps an opcode and two operands to the new accumulator
// value and the Z/N flags that value would produce.
module minibyte_alu_p
  import minibyte_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              z_o,
  output logic              n_o
);

  always_comb begin
    res_o = a_i;
    case (op_i)
      OP_LDI, OP_LDA:  res_o = b_i;
      OP_ADDI, OP_ADD: res_o = a_i + b_i;
      OP_SUBI, OP_SUB: res_o = a_i - b_i;
      OP_ANDI, OP_AND: res_o = a_i & b_i;
      OP_ORI:          res_o = a_i | b_i;
      OP_XORI:         res_o = a_i ^ b_i;
      default:         res_o = a_i;
    endcase
  end

  assign z_o = (res_o == '0);
  assign n_o = res_o[DATA_W-1];

endmodule

// File: rtl/minibyte_cpu_p.sv
// MiniByte accumulator core with parametrised data/address width and a
// request/ready memory handshake that tolerates any number of wait states.
//
// state   | meaning
// FETCH   | read opcode at PC (held off by halt_in until a request starts)
// DECODE  | classify opcode: NOP/HLT finish here, others need an operand
// OPER    | read operand at PC; immediates and jumps/branches finish here
// EXEC    | access memory at M for load/store/ALU-with-memory opcodes
// HALTED  | terminal, left only by reset
module minibyte_cpu_p
  import minibyte_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ena_in,
  input  logic              halt_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rdy_in,
  input  logic [2:0]        tm_control,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              req_out,
  output logic              we_out,
  output logic              drive_out,
  output logic [2:0]        state_out
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [ADDR_W-1:0]   m_q, m_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [1:0]          ccr_q, ccr_d;
  logic                busy_q, busy_d;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand_addr;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   bus_addr;
  logic                req;
  logic                we;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_z;
  logic                alu_n;

  assign opcode       = ir_q[3:0];
  assign operand_addr = data_in[ADDR_W-1:0];
  assign pc_inc       = pc_q + ADDR_W'(1);

  minibyte_alu_p #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i  (opcode),
    .a_i   (a_q),
    .b_i   (data_in),
    .res_o (alu_res),
    .z_o   (alu_z),
    .n_o   (alu_n)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_FETCH;
      a_q     <= '0;
      m_q     <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      ccr_q   <= '0;
      busy_q  <= 1'b0;
    end else if (ena_in) begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ccr_q   <= ccr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    m_d      = m_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ccr_d    = ccr_q;
    busy_d   = busy_q;
    req      = 1'b0;
    we       = 1'b0;
    bus_addr = pc_q;
    case (state_q)
      ST_FETCH: begin
        // busy_q keeps a started fetch alive if halt_in rises mid-access
        req = busy_q | ~halt_in;
        if (req) begin
          if (rdy_in) begin
            ir_d    = data_in;
            pc_d    = pc_inc;
            busy_d  = 1'b0;
            state_d = ST_DECODE;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (opcode == OP_NOP) begin
          state_d = ST_FETCH;
        end else if (opcode == OP_HLT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_OPER;
        end
      end
      ST_OPER: begin
        req = 1'b1;
        if (rdy_in) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
          if (is_imm_op(opcode)) begin
            a_d   = alu_res;
            ccr_d = {alu_z, alu_n};
          end else if (is_mem_op(opcode)) begin
            m_d     = operand_addr;
            state_d = ST_EXEC;
          end else if (opcode == OP_JMP) begin
            pc_d = operand_addr;
          end else if ((opcode == OP_BZ) && ccr_q[CCR_Z]) begin
            pc_d = operand_addr;
          end else if ((opcode == OP_BN) && ccr_q[CCR_N]) begin
            pc_d = operand_addr;
          end
        end
      end
      ST_EXEC: begin
        req      = 1'b1;
        bus_addr = m_q;
        we       = (opcode == OP_STA);
        if (rdy_in) begin
          state_d = ST_FETCH;
          if (opcode != OP_STA) begin
            a_d   = alu_res;
            ccr_d = {alu_z, alu_n};
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Strobes are forced low while reset is held so the bus sees an idle core
  assign req_out   = req & ~rst_in;
  assign we_out    = we & ~rst_in;
  assign drive_out = we_out;
  assign data_out  = a_q;
  assign state_out = state_q;

  always_comb begin
    addr_out = bus_addr;
    case (tm_control)
      TM_BUS:   addr_out = bus_addr;
      TM_ACC:   addr_out = a_q[ADDR_W-1:0];
      TM_ASIGN: addr_out = ADDR_W'(a_q[DATA_W-1]);
      TM_MREG:  addr_out = m_q;
      TM_PC:    addr_out = pc_q;
      TM_IR:    addr_out = ir_q[ADDR_W-1:0];
      TM_CCR:   addr_out = ADDR_W'(ccr_q);
      TM_STATE: addr_out = ADDR_W'(state_q);
      default:  addr_out = bus_addr;
    endcase
  end

endmodule

// File: tb/tb_minibyte_cpu_p.sv
// Bench for minibyte_cpu_p: 8/8 and 16/10 instances, ISA-level reference
// interpreter for program results and instruction latencies.
module tb_minibyte_cpu_p;
  import minibyte_pkg::*;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic       rst, ena, halt, rdy;
  logic [2:0] tm;

  logic [7:0]  mem8  [256];
  logic [15:0] mem16 [1024];

  logic [7:0]  din8, addr8, dout8;
  logic        req8, we8, drv8;
  logic [2:0]  st8;
  logic [15:0] din16, dout16;
  logic [9:0]  addr16;
  logic        req16, we16, drv16;
  logic [2:0]  st16;

  int ncomp = 0;
  int nfail = 0;

  logic [7:0] rmem [256];
  logic [7:0] ra, rpc;
  logic       rz, rn;

  assign din8  = mem8[addr8];
  assign din16 = mem16[addr16];

  minibyte_cpu_p #(.DATA_W(8), .ADDR_W(8)) dut8 (
    .clk_in(clk), .rst_in(rst), .ena_in(ena), .halt_in(halt), .data_in(din8),
    .rdy_in(rdy), .tm_control(tm), .addr_out(addr8), .data_out(dout8),
    .req_out(req8), .we_out(we8), .drive_out(drv8), .state_out(st8));

  minibyte_cpu_p #(.DATA_W(16), .ADDR_W(10)) dut16 (
    .clk_in(clk), .rst_in(rst), .ena_in(ena), .halt_in(halt), .data_in(din16),
    .rdy_in(rdy), .tm_control(tm), .addr_out(addr16), .data_out(dout16),
    .req_out(req16), .we_out(we16), .drive_out(drv16), .state_out(st16));

  // One clock: memory writes land on the edge where the store completes
  task automatic cycle();
    logic w8, w16;
    logic [7:0] a8, d8;
    logic [9:0] a16;
    logic [15:0] d16;
    #1;
    w8  = req8 & we8 & rdy & ena & ~rst;
    a8  = addr8;
    d8  = dout8;
    w16 = req16 & we16 & rdy & ena & ~rst;
    a16 = addr16;
    d16 = dout16;
    @(posedge clk);
    if (w8) mem8[a8] = d8;
    if (w16) mem16[a16] = d16;
    #1;
  endtask

  task automatic peek8(input logic [2:0] sel, output logic [7:0] v);
    tm = sel;
    #1;
    v = addr8;
    tm = 3'd0;
    #1;
  endtask

  task automatic clear8();
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; rdy = 1'b1; halt = 1'b0; tm = 3'd0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run8(input bit rnd, input int budget, output int ncyc);
    ncyc = 0;
    while (st8 != 3'd4 && ncyc < budget) begin
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ena = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      cycle();
      ncyc++;
    end
    rdy = 1'b1;
    ena = 1'b1;
    ncomp++;
    if (st8 !== 3'd4) begin
      nfail++;
      $display("FAIL run_timeout: state=%0d required=4 after %0d cycles", st8, ncyc);
    end
  endtask

  // Instruction-level interpreter of the current mem8 image
  task automatic model_run8(output int lat);
    logic [3:0] op;
    logic [7:0] v;
    lat = 0;
    ra = 8'h00; rz = 1'b0; rn = 1'b0; rpc = 8'h00;
    for (int i = 0; i < 256; i++) rmem[i] = mem8[i];
    for (int steps = 0; steps < 300; steps++) begin
      op = rmem[rpc][3:0];
      rpc = rpc + 8'd1;
      if (op == 4'h0) begin
        lat += 2;
        continue;
      end
      if (op == 4'hF) begin
        lat += 2;
        break;
      end
      v = rmem[rpc];
      rpc = rpc + 8'd1;
      case (op)
        4'h1: ra = v;
        4'h2: ra = rmem[v];
        4'h3: rmem[v] = ra;
        4'h4: ra = ra + v;
        4'h5: ra = ra + rmem[v];
        4'h6: ra = ra - v;
        4'h7: ra = ra - rmem[v];
        4'h8: ra = ra & v;
        4'h9: ra = ra & rmem[v];
        4'hA: ra = ra | v;
        4'hB: ra = ra ^ v;
        4'hC: rpc = v;
        4'hD: if (rz) rpc = v;
        4'hE: if (rn) rpc = v;
        default: ;
      endcase
      if (op <= 4'hB && op != 4'h3) begin
        rz = (ra == 8'h00);
        rn = ra[7];
      end
      lat += (op == 4'h2 || op == 4'h3 || op == 4'h5 || op == 4'h7 || op == 4'h9) ? 4 : 3;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    clear8();
    mem8[0] = 8'h21;
    rst = 1'b1; ena = 1'b1; rdy = 1'b1; halt = 1'b0; tm = 3'd0;
    cycle();
    cycle();
    ncomp++; if (st8 !== 3'd0) begin nfail++; $display("FAIL reset_state: got %0d required 0", st8); end
    ncomp++; if ({req8, we8, drv8} !== 3'b000) begin nfail++; $display("FAIL reset_strobes: got %b required 000", {req8, we8, drv8}); end
    ncomp++; if (dout8 !== 8'h00) begin nfail++; $display("FAIL reset_a: got %h required 00", dout8); end
    ncomp++; if (addr8 !== 8'h00) begin nfail++; $display("FAIL reset_pc: got %h required 00", addr8); end
    peek8(3'd3, v);
    ncomp++; if (v !== 8'h00) begin nfail++; $display("FAIL reset_m: got %h required 00", v); end
    peek8(3'd5, v);
    ncomp++; if (v !== 8'h00) begin nfail++; $display("FAIL reset_ir: got %h required 00", v); end
    peek8(3'd6, v);
    ncomp++; if (v !== 8'h00) begin nfail++; $display("FAIL reset_ccr: got %h required 00", v); end
    rst = 1'b0;
    #1;
    ncomp++; if (req8 !== 1'b1 || addr8 !== 8'h00) begin nfail++; $display("FAIL reset_first_fetch: req=%b addr=%h required req=1 addr=00", req8, addr8); end
  endtask

  task automatic test_ldi_addi();
    logic [7:0] v, exp_a;
    clear8();
    mem8[0] = {4'h0, OP_LDI};  mem8[1] = 8'h05;
    mem8[2] = {4'h0, OP_ADDI}; mem8[3] = 8'hFB;
    mem8[4] = {4'h0, OP_HLT};
    exp_a = 8'h05 + 8'hFB;
    do_reset();
    repeat (3) cycle();
    ncomp++; if (dout8 !== 8'h05) begin nfail++; $display("FAIL ldi_result: got %h required 05", dout8); end
    repeat (2) cycle();
    ncomp++; if (dout8 !== 8'h05) begin nfail++; $display("FAIL addi_early: got %h required 05 at cycle 5", dout8); end
    cycle();
    ncomp++; if (dout8 !== exp_a) begin nfail++; $display("FAIL addi_result: got %h required %h at cycle 6", dout8, exp_a); end
    peek8(3'd6, v);
    ncomp++; if (v !== {6'd0, exp_a == 8'h00, exp_a[7]}) begin nfail++; $display("FAIL addi_ccr: got %b required Z=1 N=0", v[1:0]); end
  endtask

  task automatic test_sta();
    int strobes, bad;
    clear8();
    mem8[0] = {4'h0, OP_LDI}; mem8[1] = 8'h81;
    mem8[2] = {4'h0, OP_STA}; mem8[3] = 8'h40;
    mem8[4] = {4'h0, OP_HLT};
    do_reset();
    strobes = 0;
    bad = 0;
    for (int i = 0; i < 30 && st8 != 3'd4; i++) begin
      if (drv8 !== we8 || (we8 && !req8)) bad++;
      if (req8 && we8) begin
        strobes++;
        ncomp++;
        if (addr8 !== 8'h40 || dout8 !== 8'h81) begin
          nfail++; $display("FAIL sta_strobe: addr=%h data=%h required addr=40 data=81", addr8, dout8);
        end
      end
      rdy = 1'b1;
      cycle();
    end
    ncomp++; if (strobes != 1) begin nfail++; $display("FAIL sta_strobe_count: got %0d required 1", strobes); end
    ncomp++; if (bad != 0) begin nfail++; $display("FAIL sta_drive_we: %0d bad cycles required 0", bad); end
    ncomp++; if (mem8[8'h40] !== 8'h81) begin nfail++; $display("FAIL sta_mem: got %h required 81", mem8[8'h40]); end
    ncomp++; if (st8 !== 3'd4) begin nfail++; $display("FAIL sta_halt: state=%0d required 4", st8); end
  endtask

  task automatic test_sta_wait();
    logic [7:0] v;
    int held, n;
    clear8();
    mem8[0] = {4'h0, OP_LDI}; mem8[1] = 8'h81;
    mem8[2] = {4'h0, OP_STA}; mem8[3] = 8'h40;
    mem8[4] = {4'h0, OP_HLT};
    do_reset();
    for (n = 0; n < 20 && st8 != 3'd3; n++) cycle();
    ncomp++; if (st8 !== 3'd3) begin nfail++; $display("FAIL sta_wait_reach_exec: state=%0d required 3", st8); end
    rdy = 1'b0;
    held = 0;
    for (int k = 0; k < 4; k++) begin
      if (req8 === 1'b1 && we8 === 1'b1 && drv8 === 1'b1 && addr8 === 8'h40 && dout8 === 8'h81) held++;
      if (k < 3) cycle();
    end
    ncomp++; if (held != 4) begin nfail++; $display("FAIL sta_wait_stable: held %0d cycles required 4", held); end
    ncomp++; if (mem8[8'h40] !== 8'h00) begin nfail++; $display("FAIL sta_wait_early_write: got %h required 00", mem8[8'h40]); end
    peek8(3'd4, v);
    ncomp++; if (v !== 8'h04) begin nfail++; $display("FAIL sta_wait_pc_hold: got %h required 04", v); end
    rdy = 1'b1;
    cycle();
    peek8(3'd4, v);
    ncomp++; if (v !== 8'h04 || st8 !== 3'd0 || we8 !== 1'b0) begin nfail++; $display("FAIL sta_wait_done: pc=%h state=%0d we=%b required pc=04 state=0 we=0", v, st8, we8); end
    ncomp++; if (mem8[8'h40] !== 8'h81) begin nfail++; $display("FAIL sta_wait_mem: got %h required 81", mem8[8'h40]); end
  endtask

  task automatic test_branch();
    logic [7:0] v;
    int lat, n;
    for (int c = 0; c < 5; c++) begin
      clear8();
      if (c < 4) begin
        mem8[0] = {4'h0, OP_LDI};
        mem8[1] = (c == 0) ? 8'h01 : (c == 1) ? 8'h00 : (c == 2) ? 8'h80 : 8'h7F;
        mem8[2] = {4'h0, (c < 2) ? OP_BZ : OP_BN}; mem8[3] = 8'h20;
        mem8[4] = {4'h0, OP_LDI}; mem8[5] = 8'h33; mem8[6] = {4'h0, OP_HLT};
        mem8[8'h20] = {4'h0, OP_LDI}; mem8[8'h21] = 8'h77; mem8[8'h22] = {4'h0, OP_HLT};
      end else begin
        mem8[0] = {4'h0, OP_JMP}; mem8[1] = 8'hFF;
        mem8[8'hFF] = {4'h0, OP_LDI};
      end
      model_run8(lat);
      do_reset();
      run8(1'b1, 500, n);
      ncomp++; if (dout8 !== ra) begin nfail++; $display("FAIL branch%0d_a: got %h required %h", c, dout8, ra); end
      peek8(3'd4, v);
      ncomp++; if (v !== rpc) begin nfail++; $display("FAIL branch%0d_pc: got %h required %h", c, v, rpc); end
    end
  endtask

  task automatic test_halt();
    int bad, n;
    clear8();
    mem8[0] = {4'h0, OP_HLT};
    do_reset();
    repeat (2) cycle();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (req8 !== 1'b0 || st8 !== 3'd4) bad++;
      rdy = ($urandom_range(0, 1) != 0);
      cycle();
    end
    ncomp++; if (bad != 0 || st8 !== 3'd4) begin nfail++; $display("FAIL hlt_stay: %0d bad cycles state=%0d required 0 bad state 4", bad, st8); end
    clear8();
    mem8[0] = {4'h0, OP_LDI}; mem8[1] = 8'h5A; mem8[2] = {4'h0, OP_HLT};
    do_reset();
    halt = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (req8 !== 1'b0 || st8 !== 3'd0) bad++;
      rdy = 1'b1;
      cycle();
    end
    ncomp++; if (bad != 0) begin nfail++; $display("FAIL halt_in_block: %0d request cycles required 0", bad); end
    halt = 1'b0;
    #1;
    ncomp++; if (req8 !== 1'b1 || addr8 !== 8'h00) begin nfail++; $display("FAIL halt_in_release: req=%b addr=%h required 1 00", req8, addr8); end
    run8(1'b0, 50, n);
    ncomp++; if (dout8 !== 8'h5A) begin nfail++; $display("FAIL halt_in_resume: got %h required 5a", dout8); end
    do_reset();
    rdy = 1'b0;
    cycle();
    halt = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (req8 !== 1'b1) bad++;
      if (i < 2) cycle();
    end
    ncomp++; if (bad != 0) begin nfail++; $display("FAIL halt_in_midfetch_req: %0d dropped cycles required 0", bad); end
    rdy = 1'b1;
    cycle();
    ncomp++; if (st8 !== 3'd1) begin nfail++; $display("FAIL halt_in_midfetch_done: state=%0d required 1", st8); end
    halt = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int n;
    clear8();
    mem8[0] = {4'h0, OP_LDI}; mem8[1] = 8'h55;
    mem8[2] = {4'h0, OP_LDA}; mem8[3] = 8'h40;
    mem8[4] = {4'h0, OP_HLT}; mem8[8'h40] = 8'h11;
    do_reset();
    for (n = 0; n < 20 && st8 != 3'd3; n++) cycle();
    rdy = 1'b0;
    cycle();
    peek8(3'd3, v);
    ncomp++; if (st8 !== 3'd3 || v !== 8'h40 || dout8 !== 8'h55) begin nfail++; $display("FAIL rstmid_setup: state=%0d m=%h a=%h required 3 40 55", st8, v, dout8); end
    rst = 1'b1;
    rdy = 1'b1;
    cycle();
    ncomp++; if (dout8 !== 8'h00) begin nfail++; $display("FAIL rstmid_a: got %h required 00", dout8); end
    ncomp++; if (st8 !== 3'd0 || req8 !== 1'b0) begin nfail++; $display("FAIL rstmid_state: state=%0d req=%b required 0 0", st8, req8); end
    peek8(3'd3, v);
    ncomp++; if (v !== 8'h00) begin nfail++; $display("FAIL rstmid_m: got %h required 00", v); end
    peek8(3'd4, v);
    ncomp++; if (v !== 8'h00) begin nfail++; $display("FAIL rstmid_pc: got %h required 00", v); end
    peek8(3'd5, v);
    ncomp++; if (v !== 8'h00) begin nfail++; $display("FAIL rstmid_ir: got %h required 00", v); end
    peek8(3'd6, v);
    ncomp++; if (v !== 8'h00) begin nfail++; $display("FAIL rstmid_ccr: got %h required 00", v); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [7:0] v;
    int p, lat, n, diffs;
    for (int t = 0; t < 8; t++) begin
      clear8();
      for (int i = 8'h80; i < 8'h90; i++) mem8[i] = 8'($urandom);
      p = 0;
      for (int k = 0; k < 14; k++) begin
        op = 4'($urandom_range(0, 11));
        mem8[p] = {4'($urandom_range(0, 15)), op};
        p++;
        if (op != 4'h0) begin
          if (op == 4'h2 || op == 4'h3 || op == 4'h5 || op == 4'h7 || op == 4'h9)
            mem8[p] = 8'h80 + 8'($urandom_range(0, 15));
          else
            mem8[p] = 8'($urandom);
          p++;
        end
      end
      mem8[p] = {4'h0, OP_HLT};
      model_run8(lat);
      do_reset();
      run8(t != 0, 3000, n);
      if (t == 0) begin
        ncomp++; if (n != lat) begin nfail++; $display("FAIL rand_latency: got %0d cycles required %0d", n, lat); end
      end
      ncomp++; if (dout8 !== ra) begin nfail++; $display("FAIL rand%0d_a: got %h required %h", t, dout8, ra); end
      peek8(3'd6, v);
      ncomp++; if (v !== {6'd0, rz, rn}) begin nfail++; $display("FAIL rand%0d_ccr: got %b required %b", t, v[1:0], {rz, rn}); end
      peek8(3'd4, v);
      ncomp++; if (v !== rpc) begin nfail++; $display("FAIL rand%0d_pc: got %h required %h", t, v, rpc); end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem8[i] !== rmem[i]) diffs++;
      ncomp++; if (diffs != 0) begin nfail++; $display("FAIL rand%0d_mem: %0d differing bytes required 0", t, diffs); end
    end
  endtask

  task automatic test_w16();
    logic [15:0] exp_a;
    int n;
    for (int i = 0; i < 1024; i++) mem16[i] = 16'h0000;
    mem16[0] = {12'h000, OP_SUBI}; mem16[1] = 16'h0001; mem16[2] = {12'h000, OP_HLT};
    exp_a = 16'h0000 - 16'h0001;
    do_reset();
    for (n = 0; n < 100 && st16 != 3'd4; n++) begin
      rdy = ($urandom_range(0, 2) != 0);
      cycle();
    end
    rdy = 1'b1;
    ncomp++; if (st16 !== 3'd4) begin nfail++; $display("FAIL w16_halt: state=%0d required 4", st16); end
    ncomp++; if (dout16 !== exp_a) begin nfail++; $display("FAIL w16_a: got %h required %h", dout16, exp_a); end
    tm = 3'd2; #1;
    ncomp++; if (addr16 !== 10'(exp_a[15])) begin nfail++; $display("FAIL w16_sign_dbg: got %h required 001", addr16); end
    tm = 3'd6; #1;
    ncomp++; if (addr16 !== {8'd0, exp_a == 16'h0000, exp_a[15]}) begin nfail++; $display("FAIL w16_ccr: got %h required 001", addr16); end
    tm = 3'd1; #1;
    ncomp++; if (addr16 !== exp_a[9:0]) begin nfail++; $display("FAIL w16_a_dbg: got %h required %h", addr16, exp_a[9:0]); end
    tm = 3'd4; #1;
    ncomp++; if (addr16 !== 10'd3) begin nfail++; $display("FAIL w16_pc: got %h required 003", addr16); end
    tm = 3'd0; #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; halt = 1'b0; rdy = 1'b1; tm = 3'd0;
    for (int i = 0; i < 1024; i++) mem16[i] = 16'h0000;
    test_reset();
    test_ldi_addi();
    test_sta();
    test_sta_wait();
    test_branch();
    test_halt();
    test_reset_mid();
    test_random();
    test_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
